bram_pixel_pack_out: RTL and testbench

Write-back stage of the lattice datapath: after a collision/streaming pass, reads the nine per-direction BRAMs pixel by pixel and packs each pixel into one 144-bit AXI-Stream beat for the DMA S2MM channel to DDR. It mirrors the inbound DDR-to-BRAM pixel stage, using the same beat layout. It absorbs BRAM read latency and AXI backpressure with a 4-entry buffer, and marks the frame end with tlast.

---
 rtl/lattice_pkg.sv | 46 ++++
 rtl/bram_pixel_pack_out_pixel_fifo.sv | 49 ++++
 rtl/bram_pixel_pack_out.sv | 129 ++++++++++++
 tb/tb_bram_pixel_pack_out.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lattice_pkg.sv
// Shared lattice datapath definitions: direction layout of a packed pixel beat
// and the write-back FSM state encoding.
package lattice_pkg;

   localparam int DIR_COUNT   = 9;
   localparam int DIR_WIDTH   = 16;
   localparam int PIXEL_WIDTH = DIR_COUNT * DIR_WIDTH;

   localparam int N_OFF    = 0;
   localparam int NULL_OFF = 16;
   localparam int NE_OFF   = 32;
   localparam int E_OFF    = 48;
   localparam int SE_OFF   = 64;
   localparam int S_OFF    = 80;
   localparam int SW_OFF   = 96;
   localparam int W_OFF    = 112;
   localparam int NW_OFF   = 128;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   function automatic logic [PIXEL_WIDTH-1:0] pack_pixel(
      input logic [DIR_WIDTH-1:0] n,  input logic [DIR_WIDTH-1:0] nul,
      input logic [DIR_WIDTH-1:0] ne, input logic [DIR_WIDTH-1:0] e,
      input logic [DIR_WIDTH-1:0] se, input logic [DIR_WIDTH-1:0] s,
      input logic [DIR_WIDTH-1:0] sw, input logic [DIR_WIDTH-1:0] w,
      input logic [DIR_WIDTH-1:0] nw);
      logic [PIXEL_WIDTH-1:0] p;
      p = '0;
      p[N_OFF    +: DIR_WIDTH] = n;
      p[NULL_OFF +: DIR_WIDTH] = nul;
      p[NE_OFF   +: DIR_WIDTH] = ne;
      p[E_OFF    +: DIR_WIDTH] = e;
      p[SE_OFF   +: DIR_WIDTH] = se;
      p[S_OFF    +: DIR_WIDTH] = s;
      p[SW_OFF   +: DIR_WIDTH] = sw;
      p[W_OFF    +: DIR_WIDTH] = w;
      p[NW_OFF   +: DIR_WIDTH] = nw;
      return p;
   endfunction

endpackage

// File: rtl/bram_pixel_pack_out_pixel_fifo.sv
// Four-entry synchronous FIFO holding packed pixels plus their last-beat flag.
module pixel_fifo #(
   parameter int WIDTH = 145
) (
   input  logic             m00_axis_aclk,
   input  logic             m00_axis_areset,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic [2:0]       count,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem [4];
   logic [1:0]       wr_ptr;
   logic [1:0]       rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == 3'd4);
   assign empty   = (count == 3'd0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge m00_axis_aclk or posedge m00_axis_areset) begin
      if (m00_axis_areset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 2'd1;
         if (do_pop)  rd_ptr <= rd_ptr + 2'd1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 3'd1;
            2'b01:   count <= count - 3'd1;
            default: count <= count;
         endcase
      end
   end

   // Storage is data only; emptiness is tracked by the pointers and count.
   always_ff @(posedge m00_axis_aclk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/bram_pixel_pack_out.sv
// Write-back stage: reads the nine direction BRAMs pixel by pixel and streams
// each pixel as one 144-bit AXI-Stream beat, tlast on the final pixel.
module bram_pixel_pack_out
   import lattice_pkg::*;
#(
   parameter int DATA_WIDTH    = 16,
   parameter int DEPTH         = 2500,
   parameter int ADDRESS_WIDTH = 12,
   parameter int READ_LATENCY  = 1
) (
   input  logic                     m00_axis_aclk,
   input  logic                     m00_axis_areset,
   input  logic                     start,
   output logic [ADDRESS_WIDTH-1:0] read_addr,
   output logic                     read_en,
   input  logic [DATA_WIDTH-1:0]    n_rd,
   input  logic [DATA_WIDTH-1:0]    null_rd,
   input  logic [DATA_WIDTH-1:0]    ne_rd,
   input  logic [DATA_WIDTH-1:0]    e_rd,
   input  logic [DATA_WIDTH-1:0]    se_rd,
   input  logic [DATA_WIDTH-1:0]    s_rd,
   input  logic [DATA_WIDTH-1:0]    sw_rd,
   input  logic [DATA_WIDTH-1:0]    w_rd,
   input  logic [DATA_WIDTH-1:0]    nw_rd,
   output logic                     m00_axis_tvalid,
   output logic [PIXEL_WIDTH-1:0]   m00_axis_tdata,
   output logic [PIXEL_WIDTH/8-1:0] m00_axis_tstrb,
   output logic                     m00_axis_tlast,
   input  logic                     m00_axis_tready,
   output logic                     busy,
   output logic                     done
);

   state_t                   state;
   logic [READ_LATENCY-1:0]  rd_vld_p;
   logic [READ_LATENCY-1:0]  rd_last_p;
   logic [2:0]               inflight;
   logic [2:0]               fifo_count;
   logic                     fifo_full;
   logic                     fifo_empty;
   logic [PIXEL_WIDTH:0]     fifo_head;
   logic                     push;
   logic                     pop;
   logic                     last_addr;

   always_comb begin
      inflight = '0;
      for (int i = 0; i < READ_LATENCY; i++) inflight = inflight + 3'(rd_vld_p[i]);
   end

   // A read is issued only if its beat is guaranteed a buffer slot on return.
   assign read_en   = (state == READ) && !fifo_full &&
                      (({1'b0, fifo_count} + {1'b0, inflight}) < 4'd4);
   assign last_addr = (read_addr == ADDRESS_WIDTH'(DEPTH - 1));
   assign push      = rd_vld_p[READ_LATENCY-1];
   assign pop       = m00_axis_tvalid & m00_axis_tready;

   assign m00_axis_tvalid = !fifo_empty;
   assign m00_axis_tdata  = fifo_empty ? '0 : fifo_head[PIXEL_WIDTH-1:0];
   assign m00_axis_tlast  = fifo_empty ? 1'b0 : fifo_head[PIXEL_WIDTH];
   assign m00_axis_tstrb  = '1;

   always_ff @(posedge m00_axis_aclk or posedge m00_axis_areset) begin
      if (m00_axis_areset) begin
         state     <= IDLE;
         read_addr <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  state     <= READ;
                  read_addr <= '0;
                  busy      <= 1'b1;
               end
            end
            READ: begin
               if (read_en) begin
                  if (last_addr) state <= DRAIN;
                  else           read_addr <= read_addr + 1'b1;
               end
            end
            DRAIN: begin
               if (pop && fifo_head[PIXEL_WIDTH] && fifo_count == 3'd1 && inflight == 3'd0) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               done  <= 1'b0;
            end
         endcase
      end
   end

   // Read-latency pipeline: one valid and last-pixel flag per outstanding read.
   always_ff @(posedge m00_axis_aclk or posedge m00_axis_areset) begin
      if (m00_axis_areset) begin
         rd_vld_p  <= '0;
         rd_last_p <= '0;
      end else begin
         rd_vld_p[0]  <= read_en;
         rd_last_p[0] <= read_en & last_addr;
         for (int i = 1; i < READ_LATENCY; i++) begin
            rd_vld_p[i]  <= rd_vld_p[i-1];
            rd_last_p[i] <= rd_last_p[i-1];
         end
      end
   end

   pixel_fifo #(.WIDTH(PIXEL_WIDTH + 1)) u_fifo (
      .m00_axis_aclk   (m00_axis_aclk),
      .m00_axis_areset (m00_axis_areset),
      .push            (push),
      .din             ({rd_last_p[READ_LATENCY-1],
                         pack_pixel(n_rd, null_rd, ne_rd, e_rd, se_rd,
                                    s_rd, sw_rd, w_rd, nw_rd)}),
      .pop             (pop),
      .dout            (fifo_head),
      .count           (fifo_count),
      .full            (fifo_full),
      .empty           (fifo_empty)
   );

endmodule

// File: tb/tb_bram_pixel_pack_out.sv
// Directed bench: three instances (latency 1, latency 2, single-pixel frame)
// each fed by a BRAM model returning dir k = {k, addr}.
module tb_bram_pixel_pack_out;

   logic         clk = 1'b0;
   logic         rst;
   logic         st   [3];
   logic         rdy  [3];
   logic         re   [3];
   logic         tv   [3];
   logic         tl   [3];
   logic         bz   [3];
   logic         dn   [3];
   logic [11:0]  ra   [3];
   logic [143:0] td   [3];
   logic [17:0]  ts   [3];
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_inst
      localparam int RL  = (g == 1) ? 2 : 1;
      localparam int DEP = (g == 2) ? 1 : 2500;
      logic [11:0] q0, q1, qa;
      always @(posedge clk) begin
         if (re[g]) q0 <= ra[g];
         q1 <= q0;
      end
      assign qa = (RL == 2) ? q1 : q0;

      bram_pixel_pack_out #(
         .DATA_WIDTH(16), .DEPTH(DEP), .ADDRESS_WIDTH(12), .READ_LATENCY(RL)
      ) u_dut (
         .m00_axis_aclk   (clk),
         .m00_axis_areset (rst),
         .start           (st[g]),
         .read_addr       (ra[g]),
         .read_en         (re[g]),
         .n_rd            ({4'd0, qa}),
         .null_rd         ({4'd1, qa}),
         .ne_rd           ({4'd2, qa}),
         .e_rd            ({4'd3, qa}),
         .se_rd           ({4'd4, qa}),
         .s_rd            ({4'd5, qa}),
         .sw_rd           ({4'd6, qa}),
         .w_rd            ({4'd7, qa}),
         .nw_rd           ({4'd8, qa}),
         .m00_axis_tvalid (tv[g]),
         .m00_axis_tdata  (td[g]),
         .m00_axis_tstrb  (ts[g]),
         .m00_axis_tlast  (tl[g]),
         .m00_axis_tready (rdy[g]),
         .busy            (bz[g]),
         .done            (dn[g])
      );
   end

   function automatic logic [143:0] exp_pix(input int a);
      logic [143:0] r;
      logic [3:0]   k4;
      logic [11:0]  a12;
      r   = '0;
      a12 = 12'(a);
      for (int k = 0; k < 9; k++) begin
         k4 = 4'(k);
         r[16*k +: 16] = {k4, a12};
      end
      return r;
   endfunction

   // mode 0: tready high, 1: random tready, 2: 20-cycle stall at beat 100,
   // 3: stray start pulses at beats 10, 2499 and during DONE.
   task automatic run_frame(input int i, input int mode, input string name);
      int dep, rl, idx, issued, cyc, done_cnt, bubbles, max_out, stall;
      int last_cnt, stab_err, post_done, data_err;
      bit stalled_done, p10, p2499, pdone, prev_hold, seen_done;
      logic [143:0] prev_d;
      logic prev_l;
      dep = (i == 2) ? 1 : 2500;
      rl  = (i == 1) ? 2 : 1;
      idx = 0; issued = 0; cyc = 0; done_cnt = 0; bubbles = 0; max_out = 0;
      stall = 0; last_cnt = 0; stab_err = 0; post_done = 0; data_err = 0;
      stalled_done = 0; p10 = 0; p2499 = 0; pdone = 0; prev_hold = 0; seen_done = 0;
      prev_d = '0; prev_l = 1'b0;
      @(negedge clk); st[i] = 1'b1;
      @(posedge clk);
      @(negedge clk); st[i] = 1'b0;
      while (post_done < 4 && cyc < 20000) begin
         if (dn[i]) begin
            done_cnt++;
            if (!seen_done) begin
               seen_done = 1;
               if (mode == 0) begin
                  checks++;
                  if (cyc !== dep + rl + 1) begin
                     errors++;
                     $display("FAIL %s frame_length: done at cycle %0d, expected %0d", name, cyc, dep + rl + 1);
                  end
               end
            end
         end
         if (seen_done) post_done++;
         if (prev_hold && (!tv[i] || td[i] !== prev_d || tl[i] !== prev_l)) stab_err++;
         st[i] = 1'b0;
         case (mode)
            1: rdy[i] = 1'($urandom_range(0, 1));
            2: begin
               if (idx == 100 && !stalled_done) begin
                  rdy[i] = 1'b0;
                  stall++;
                  if (stall == 20) begin
                     stalled_done = 1;
                     checks++;
                     if (re[i] !== 1'b0 || issued - idx != 4) begin
                        errors++;
                        $display("FAIL %s stall_full: read_en %b outstanding %0d, expected 0 and 4", name, re[i], issued - idx);
                     end
                  end
               end else rdy[i] = 1'b1;
            end
            3: begin
               rdy[i] = 1'b1;
               if (idx == 10 && !p10) begin st[i] = 1'b1; p10 = 1; end
               if (idx == 2499 && !p2499) begin st[i] = 1'b1; p2499 = 1; end
               if (dn[i] && !pdone) begin st[i] = 1'b1; pdone = 1; end
            end
            default: rdy[i] = 1'b1;
         endcase
         if (re[i]) begin
            checks++;
            if (ra[i] !== 12'(issued)) begin
               errors++;
               $display("FAIL %s read_addr: got %0d, expected %0d", name, ra[i], issued);
            end
            issued++;
         end
         if (issued - idx > max_out) max_out = issued - idx;
         if (tv[i] && rdy[i]) begin
            if (td[i] !== exp_pix(idx) || tl[i] !== (idx == dep - 1)) begin
               data_err++;
               if (data_err < 5)
                  $display("FAIL %s beat %0d: tdata %h tlast %b, expected %h %b", name, idx, td[i], tl[i], exp_pix(idx), idx == dep - 1);
            end
            if (tl[i]) last_cnt++;
            idx++;
         end else if (mode == 0 && idx > 0 && idx < dep && !tv[i]) bubbles++;
         prev_hold = tv[i] && !rdy[i];
         prev_d = td[i];
         prev_l = tl[i];
         @(posedge clk); cyc++;
         @(negedge clk);
      end
      st[i] = 1'b0; rdy[i] = 1'b0;
      checks++;
      if (cyc >= 20000) begin errors++; $display("FAIL %s timeout: %0d beats seen, expected %0d", name, idx, dep); end
      checks++;
      if (data_err != 0) begin errors++; $display("FAIL %s data: %0d bad beats, expected 0", name, data_err); end
      checks++;
      if (idx != dep || issued != dep) begin errors++; $display("FAIL %s counts: beats %0d reads %0d, expected %0d", name, idx, issued, dep); end
      checks++;
      if (done_cnt != 1 || last_cnt != 1) begin errors++; $display("FAIL %s done_tlast: done %0d tlast %0d, expected 1 1", name, done_cnt, last_cnt); end
      checks++;
      if (stab_err != 0) begin errors++; $display("FAIL %s stall_stability: %0d changes, expected 0", name, stab_err); end
      checks++;
      if (max_out > 4) begin errors++; $display("FAIL %s outstanding: max %0d, expected <= 4", name, max_out); end
      checks++;
      if (bubbles != 0) begin errors++; $display("FAIL %s bubbles: %0d, expected 0", name, bubbles); end
      checks++;
      if (bz[i] !== 1'b0 || tv[i] !== 1'b0 || ra[i] !== 12'(dep - 1)) begin
         errors++;
         $display("FAIL %s idle_after: busy %b tvalid %b addr %0d, expected 0 0 %0d", name, bz[i], tv[i], ra[i], dep - 1);
      end
   endtask

   task automatic check_zero(input int i, input string name);
      checks++;
      if (tv[i] !== 1'b0 || td[i] !== '0 || tl[i] !== 1'b0 || bz[i] !== 1'b0 ||
          dn[i] !== 1'b0 || re[i] !== 1'b0 || ra[i] !== 12'd0) begin
         errors++;
         $display("FAIL %s: tvalid %b tdata %h tlast %b busy %b done %b read_en %b addr %0d, expected all 0",
                  name, tv[i], td[i], tl[i], bz[i], dn[i], re[i], ra[i]);
      end
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) check_zero(i, "reset_state");
      checks++;
      if (ts[0] !== 18'h3ffff) begin errors++; $display("FAIL tstrb: got %h, expected 3ffff", ts[0]); end
      @(negedge clk); rst = 1'b0;
      repeat (2) @(negedge clk);
      check_zero(0, "after_release");
   endtask

   task automatic test_reset_mid(input logic tr, input string name);
      int idx, cyc, bad;
      idx = 0; cyc = 0; bad = 0;
      @(negedge clk); st[0] = 1'b1;
      @(negedge clk); st[0] = 1'b0; rdy[0] = 1'b1;
      while (idx < 1000 && cyc < 5000) begin
         if (tv[0] && rdy[0]) idx++;
         @(negedge clk); cyc++;
      end
      rdy[0] = tr;
      #2 rst = 1'b1;
      #1 check_zero(0, name);
      @(negedge clk); rst = 1'b0;
      rdy[0] = 1'b1;
      repeat (5) begin
         @(negedge clk);
         if (tv[0] !== 1'b0 || re[0] !== 1'b0 || bz[0] !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL %s post_release: %0d active cycles, expected 0", name, bad); end
      rdy[0] = 1'b0;
      run_frame(0, 0, {name, "_refill"});
   endtask

   task automatic test_full_frame();      run_frame(0, 0, "full_frame_rl1"); run_frame(1, 0, "full_frame_rl2"); endtask
   task automatic test_random_ready();    run_frame(0, 1, "random_rl1");     run_frame(1, 1, "random_rl2");     endtask
   task automatic test_stall();           run_frame(0, 2, "stall_at_100");   endtask
   task automatic test_start_ignored();   run_frame(0, 3, "start_ignored");  endtask
   task automatic test_depth_one();       run_frame(2, 0, "depth_one");      endtask

   initial begin
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin st[i] = 1'b0; rdy[i] = 1'b0; end
      repeat (3) @(posedge clk);
      @(negedge clk);
      test_reset();
      test_full_frame();
      test_random_ready();
      test_stall();
      test_start_ignored();
      test_reset_mid(1'b1, "reset_mid_ready_high");
      test_reset_mid(1'b0, "reset_mid_ready_low");
      test_depth_one();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
